// File: rtl/result_pipe_regs_pkg.sv
// Shared types for the EX/MEM and MEM/WB result pipeline registers.
// Stage control word, the zero register index and the bubble encoding.
package pipe_pkg;

    localparam int PIPE_REG_W = 5;

    typedef struct packed {
        logic [PIPE_REG_W-1:0] rd;
        logic                  we;
        logic                  wb_sel;
        logic                  vec;
    } stage_ctrl_t;

    localparam logic [PIPE_REG_W-1:0] ZERO_REG = '0;

    // wb_sel=1 keeps a bubble from pulling load data into WB.
    localparam stage_ctrl_t BUBBLE = '{rd: ZERO_REG, we: 1'b0, wb_sel: 1'b1, vec: 1'b0};

endpackage

// File: rtl/result_pipe_regs_if.sv
// Bus between the EX/MEM/WB result pipeline and its surroundings.
// Optional RESULT_PIPE_PERF_EN adds the stall/busy performance counters.
interface result_pipe_regs_if #(
    parameter int DATA_W = 128,
    parameter int REG_W  = 5
);
    logic              ex_valid;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_we;
    logic              ex_wb_sel;
    logic              ex_vec;
    logic [DATA_W-1:0] ex_result;
    logic              stall;
    logic              flush;
    logic              mem_busy;
    logic [DATA_W-1:0] mem_rdata;

    logic [REG_W-1:0]  rd_mem;
    logic              write_enable_mem;
    logic              wb_sel_mem;
    logic [DATA_W-1:0] result_mem;
    logic [REG_W-1:0]  rd_wb;
    logic              write_enable_wb;
    logic              vec_wb;
    logic [DATA_W-1:0] result_wb;
    logic              rf_we;
    logic              vrf_we;
`ifdef RESULT_PIPE_PERF_EN
    logic [31:0]       stall_count;
    logic [31:0]       busy_count;
`endif

    modport master (
        output ex_valid, ex_rd, ex_we, ex_wb_sel, ex_vec, ex_result,
        output stall, flush, mem_busy, mem_rdata,
        input  rd_mem, write_enable_mem, wb_sel_mem, result_mem,
        input  rd_wb, write_enable_wb, vec_wb, result_wb, rf_we, vrf_we
`ifdef RESULT_PIPE_PERF_EN
        , input stall_count, busy_count
`endif
    );

    modport slave (
        input  ex_valid, ex_rd, ex_we, ex_wb_sel, ex_vec, ex_result,
        input  stall, flush, mem_busy, mem_rdata,
        output rd_mem, write_enable_mem, wb_sel_mem, result_mem,
        output rd_wb, write_enable_wb, vec_wb, result_wb, rf_we, vrf_we
`ifdef RESULT_PIPE_PERF_EN
        , output stall_count, busy_count
`endif
    );

endinterface

// File: rtl/result_pipe_regs_stage_reg.sv
// One pipeline stage register: control word plus payload with hold/bubble/load.
// A bubble replaces only the control word; the payload keeps its old value.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_i,
    input  logic              bubble_i,
    input  stage_ctrl_t       ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output stage_ctrl_t       ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    stage_ctrl_t       ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        // NOTE: defaults first so every path assigns ctrl_d/data_d; otherwise a latch is inferred.
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (!hold_i) begin
            if (bubble_i) begin
                ctrl_d = BUBBLE;
            end else begin
                ctrl_d = ctrl_i;
                data_d = data_i;
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/result_pipe_regs.sv
// EX/MEM and MEM/WB result pipeline registers driving the scalar/vector RF write ports.
// Define RESULT_PIPE_PERF_EN to add saturating stall_count/busy_count counters.
module result_pipe_regs
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int REG_W  = PIPE_REG_W
) (
    input logic              clk,
    input logic              rst_n,
    result_pipe_regs_if.slave bus
);

    stage_ctrl_t       mem_in, mem_ctrl, wb_ctrl;
    logic [DATA_W-1:0] mem_data, wb_in_data, wb_data;
    logic              we_eff;

    // Writes to register 0 are dropped here so no later stage has to care.
    assign we_eff = bus.ex_valid & bus.ex_we & (bus.ex_rd != REG_W'(ZERO_REG));

    always_comb begin
        mem_in        = BUBBLE;
        mem_in.rd     = PIPE_REG_W'(bus.ex_rd);
        mem_in.we     = we_eff;
        mem_in.wb_sel = bus.ex_wb_sel;
        mem_in.vec    = bus.ex_vec;
    end

    pipe_stage_reg #(.DATA_W(DATA_W)) u_mem_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (bus.mem_busy),
        .bubble_i (bus.flush | bus.stall),
        .ctrl_i   (mem_in),
        .data_i   (bus.ex_result),
        .ctrl_o   (mem_ctrl),
        .data_o   (mem_data)
    );

    assign wb_in_data = mem_ctrl.wb_sel ? mem_data : bus.mem_rdata;

    pipe_stage_reg #(.DATA_W(DATA_W)) u_wb_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (bus.mem_busy),
        .bubble_i (1'b0),
        .ctrl_i   (mem_ctrl),
        .data_i   (wb_in_data),
        .ctrl_o   (wb_ctrl),
        .data_o   (wb_data)
    );

    // The result mux already resolved wb_sel before WB, so its WB copy is dead.
    logic unused_wb_sel;
    assign unused_wb_sel = wb_ctrl.wb_sel;

    assign bus.rd_mem           = REG_W'(mem_ctrl.rd);
    assign bus.write_enable_mem = mem_ctrl.we;
    assign bus.wb_sel_mem       = mem_ctrl.wb_sel;
    assign bus.result_mem       = mem_data;
    assign bus.rd_wb            = REG_W'(wb_ctrl.rd);
    assign bus.write_enable_wb  = wb_ctrl.we;
    assign bus.vec_wb           = wb_ctrl.vec;
    assign bus.result_wb        = wb_data;
    assign bus.rf_we            = wb_ctrl.we & ~wb_ctrl.vec & ~bus.mem_busy;
    assign bus.vrf_we           = wb_ctrl.we &  wb_ctrl.vec & ~bus.mem_busy;

`ifdef RESULT_PIPE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] busy_cnt_q, busy_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        busy_cnt_d  = busy_cnt_q;
        if (bus.stall && !bus.mem_busy && !bus.flush && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (bus.mem_busy && busy_cnt_q != '1) begin
            busy_cnt_d = busy_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            busy_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign bus.stall_count = stall_cnt_q;
    assign bus.busy_count  = busy_cnt_q;
`endif

endmodule

// File: tb/tb_result_pipe_regs.sv
// Scoreboard bench for result_pipe_regs: an instruction-level model predicts MEM contents
// and register-file writes; a negedge monitor compares them against the DUT.
module tb_result_pipe_regs;

    localparam int DATA_W = 128;
    localparam int REG_W  = 5;

    typedef logic [DATA_W-1:0] data_t;
    typedef struct {
        logic [REG_W-1:0] rd;
        logic             vec;
        data_t            data;
    } rf_write_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    result_pipe_regs_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

    result_pipe_regs #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference: what sits in MEM and which RF writes are owed, in program order.
    rf_write_t        exp_q[$];
    rf_write_t        mon_w;
    logic [REG_W-1:0] m_rd;
    logic             m_we, m_wb_sel, m_vec;
    data_t            m_result;
    logic [31:0]      m_stall_cnt, m_busy_cnt;

    task automatic check(input string name, input data_t act, input data_t exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic data_t rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_rd = '0; m_we = 1'b0; m_wb_sel = 1'b0; m_vec = 1'b0; m_result = '0;
        m_stall_cnt = '0; m_busy_cnt = '0;
        exp_q.delete();
    endtask

    // Applied once per rising edge, using the inputs that were stable across it.
    task automatic model_edge();
        if (bus.mem_busy) begin
            if (m_busy_cnt != 32'hFFFF_FFFF) m_busy_cnt++;
            return;
        end
        if (m_we) begin
            mon_w.rd   = m_rd;
            mon_w.vec  = m_vec;
            mon_w.data = m_wb_sel ? m_result : bus.mem_rdata;
            exp_q.push_back(mon_w);
        end
        if (bus.flush || bus.stall) begin
            if (!bus.flush && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            m_rd = '0; m_we = 1'b0; m_wb_sel = 1'b1; m_vec = 1'b0;
        end else begin
            m_rd     = bus.ex_rd;
            m_we     = bus.ex_valid && bus.ex_we && (bus.ex_rd != 0);
            m_wb_sel = bus.ex_wb_sel;
            m_vec    = bus.ex_vec;
            m_result = bus.ex_result;
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [REG_W-1:0] rd,
                         input logic wbs, input logic vec, input data_t res,
                         input logic st, input logic fl, input logic busy, input data_t rdata);
        bus.ex_valid = v;  bus.ex_we = we;   bus.ex_rd = rd;     bus.ex_wb_sel = wbs;
        bus.ex_vec = vec;  bus.ex_result = res;
        bus.stall = st;    bus.flush = fl;   bus.mem_busy = busy; bus.mem_rdata = rdata;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_mem"},           data_t'(bus.rd_mem), '0);
        check({tag, " write_enable_mem"}, data_t'(bus.write_enable_mem), '0);
        check({tag, " wb_sel_mem"},       data_t'(bus.wb_sel_mem), '0);
        check({tag, " result_mem"},       bus.result_mem, '0);
        check({tag, " rd_wb"},            data_t'(bus.rd_wb), '0);
        check({tag, " write_enable_wb"},  data_t'(bus.write_enable_wb), '0);
        check({tag, " vec_wb"},           data_t'(bus.vec_wb), '0);
        check({tag, " result_wb"},        bus.result_wb, '0);
        check({tag, " rf_we"},            data_t'(bus.rf_we), '0);
        check({tag, " vrf_we"},           data_t'(bus.vrf_we), '0);
    endtask

    // Monitor: MEM stage every cycle, and one owed RF write per non-busy cycle.
    initial begin
        forever begin
            @(negedge clk);
            check("rd_mem",           data_t'(bus.rd_mem), data_t'(m_rd));
            check("write_enable_mem", data_t'(bus.write_enable_mem), data_t'(m_we));
            check("wb_sel_mem",       data_t'(bus.wb_sel_mem), data_t'(m_wb_sel));
            check("result_mem",       bus.result_mem, m_result);
            if (exp_q.size() > 0 && !bus.mem_busy) begin
                mon_w = exp_q.pop_front();
                check("rf_we",           data_t'(bus.rf_we), data_t'(!mon_w.vec));
                check("vrf_we",          data_t'(bus.vrf_we), data_t'(mon_w.vec));
                check("write_enable_wb", data_t'(bus.write_enable_wb), data_t'(1'b1));
                check("rd_wb",           data_t'(bus.rd_wb), data_t'(mon_w.rd));
                check("result_wb",       bus.result_wb, mon_w.data);
            end else begin
                check("rf_we idle",  data_t'(bus.rf_we), '0);
                check("vrf_we idle", data_t'(bus.vrf_we), '0);
                if (exp_q.size() > 0) begin
                    check("write_enable_wb held", data_t'(bus.write_enable_wb), data_t'(1'b1));
                    check("rd_wb held",           data_t'(bus.rd_wb), data_t'(exp_q[0].rd));
                end
            end
`ifdef RESULT_PIPE_PERF_EN
            check("stall_count", data_t'(bus.stall_count), data_t'(m_stall_cnt));
            check("busy_count",  data_t'(bus.busy_count), data_t'(m_busy_cnt));
`endif
        end
    end

    initial begin
        drive(0, 0, '0, 0, 0, '0, 0, 0, 0, '0);
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Directed: ALU write, load, load then stall, flush+stall, busy hold, rd=0, vector.
        drive(1, 1, 5'd3, 1, 0, data_t'(64'h1234567890ABCDEF), 0, 0, 0, rnd_data());
        step();
        drive(1, 1, 5'd4, 0, 0, data_t'(64'h0000_0000_DEAD_BEEF), 0, 0, 0, rnd_data());
        step();
        drive(1, 1, 5'd17, 0, 0, rnd_data(), 0, 0, 0, data_t'(64'hFEDCBA0987654321));
        step();
        drive(1, 1, 5'd5, 1, 0, data_t'(64'h5555), 1, 0, 0, data_t'(64'h1717));
        step();
        drive(1, 1, 5'd5, 1, 0, data_t'(64'h5555), 0, 0, 0, rnd_data());
        step();
        drive(1, 1, 5'd6, 1, 0, data_t'(64'h6666), 1, 1, 0, rnd_data());
        step();
        drive(1, 1, 5'd7, 1, 0, data_t'(64'h7777), 0, 0, 0, rnd_data());
        step();
        drive(1, 1, 5'd8, 1, 0, data_t'(64'h8888), 0, 0, 0, rnd_data());
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'd9, 1, 0, rnd_data(), 0, 0, 1, rnd_data());
            step();
        end
        drive(1, 1, 5'd0, 1, 0, data_t'(64'hBAD0), 0, 0, 0, rnd_data());
        step();
        drive(1, 1, 5'd10, 1, 1, rnd_data(), 0, 0, 0, rnd_data());
        step();
        drive(0, 1, 5'd11, 1, 0, rnd_data(), 0, 0, 0, rnd_data());
        step();

        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                  REG_W'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, rnd_data(),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 6) == 0, rnd_data());
            step();
        end

        // Reset in the middle of a busy stretch clears everything without a clock edge.
        drive(1, 1, 5'd12, 1, 0, rnd_data(), 0, 0, 0, rnd_data());
        step();
        drive(1, 1, 5'd13, 1, 1, rnd_data(), 0, 0, 1, rnd_data());
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("async reset");
        drive(1, 1, 5'd14, 1, 0, data_t'(64'h1414), 0, 0, 0, rnd_data());
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 1) == 1, 1'b1, REG_W'($urandom_range(0, 31)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rnd_data(),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0, rnd_data());
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, '0, 1, 0, '0, 0, 0, 0, '0);
            step();
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
